alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter N, default 64, operand/result width in bits; SHALL support any N >= 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 a  input  N  first operand.
REQ-005 b  input  N  second operand.
REQ-006 ALUControl  input  4  operation select.
REQ-007 result  output  N  registered operation result.
REQ-008 zero  output  1  registered flag, 1 when result is all zeros.

Function
REQ-009 SHALL sample a, b, ALUControl on each rising clk edge with reset low and present the outcome on result/zero after that edge; latency exactly 1 cycle, throughput 1 op/cycle.
REQ-010 Outputs SHALL hold stable between rising edges, independent of input changes.
REQ-011 ALUControl 0000 SHALL yield a AND b (bitwise).
REQ-012 ALUControl 0001 SHALL yield a OR b (bitwise).
REQ-013 ALUControl 0010 SHALL yield a + b modulo 2^N; carry-out discarded, no overflow flag.
REQ-014 ALUControl 0110 SHALL yield a - b modulo 2^N (two's complement wrap, e.g. 0 - 1 = all ones).
REQ-015 ALUControl 0111 SHALL yield b unchanged (pass-through for compare-branch use).
REQ-016 ALUControl 1100 SHALL yield NOT (a OR b) (bitwise NOR).
REQ-017 ALUControl 0011 SHALL yield a XOR b.
REQ-018 ALUControl 1000 SHALL yield a shifted left logically by b[$clog2(N)-1:0]; vacated bits 0.
REQ-019 ALUControl 1001 SHALL yield a shifted right logically by b[$clog2(N)-1:0]; vacated bits 0.
REQ-020 Any other ALUControl value SHALL yield result 0 (and hence zero 1).
REQ-021 zero SHALL equal 1 exactly when the registered result equals 0, computed from the same operation so both outputs update on the same edge.
REQ-022 Operands SHALL be treated as unsigned bit vectors; no sign extension or saturation anywhere.
REQ-023 Outputs SHALL never be X/Z after the first reset edge when inputs are known.

Reset
REQ-024 With reset high at a rising edge, result SHALL become 0 and zero SHALL become 1 on that edge, regardless of a, b, ALUControl.
REQ-025 Reset asserted mid-stream SHALL discard the operation sampled on that edge; the first valid result appears 1 cycle after the first edge with reset low.
REQ-026 Before the first reset edge outputs are undefined; no asynchronous behaviour permitted.

Verification
REQ-027 Reset high 2 edges -> result 0, zero 1; then a=5, b=3, ALUControl 0010 -> next edge result 8, zero 0.
REQ-028 a=7, b=7, ALUControl 0110 -> result 0, zero 1; a=0, b=1, 0110 -> result 0xFFFF_FFFF_FFFF_FFFF, zero 0.
REQ-029 a=0xFFFF_FFFF_FFFF_FFFF, b=1, 0010 -> result 0, zero 1 (wrap-around).
REQ-030 a=0xF0, b=0x3C: 0000 -> 0x30; 0001 -> 0xFC; 1100 -> 0xFFFF_FFFF_FFFF_FF03; 0011 -> 0xCC; 0111 -> 0x3C.
REQ-031 a=1, b=63, 1000 -> result 0x8000_0000_0000_0000; a=0x80, b=7, 1001 -> result 1; ALUControl 1111 -> result 0, zero 1.
REQ-032 Back-to-back distinct ops every cycle, reset pulsed one cycle mid-sequence -> each result appears exactly 1 cycle after its inputs, reset cycle shows 0/1, following op resumes correctly.

Source files
------------

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- single-cycle registered ALU
//
// Samples a, b and ALUControl on every rising clk edge. The selected
// operation's result and its zero flag are registered on that same edge, so
// the latency is one cycle and a new operation can start every cycle.
//
// Ports
//   clk         in   1   single clock, all state on the rising edge
//   reset       in   1   synchronous active-high reset (result 0, zero 1)
//   a           in   N   first operand (unsigned)
//   b           in   N   second operand (unsigned); low bits are shift amount
//   ALUControl  in   4   operation select
//   result      out  N   registered result
//   zero        out  1   registered flag, 1 when result is all zeros
//
// Operation map (ALUControl)
//   0000 AND   0001 OR    0010 ADD   0110 SUB   0111 pass b
//   1100 NOR   0011 XOR   1000 SLL   1001 SRL   others -> 0
// ---------------------------------------------------------------------------
module alu #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic [N-1:0] result,
    output logic         zero
);

    localparam int SW = $clog2(N);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SUB  = 4'b0110,
        OP_PASS = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_NOR  = 4'b1100
    } alu_op_e;

    logic [SW-1:0] shamt;
    logic [N-1:0]  res_nxt;

    // Only the low log2(N) bits of b form the shift amount; for non-power-of-2
    // N an amount >= N simply shifts everything out.
    assign shamt = b[SW-1:0];

    always_comb begin
        res_nxt = '0;
        case (ALUControl)
            OP_AND:  res_nxt = a & b;
            OP_OR:   res_nxt = a | b;
            OP_ADD:  res_nxt = a + b;   // carry-out dropped
            OP_SUB:  res_nxt = a - b;   // two's complement wrap
            OP_PASS: res_nxt = b;
            OP_NOR:  res_nxt = ~(a | b);
            OP_XOR:  res_nxt = a ^ b;
            OP_SLL:  res_nxt = a << shamt;
            OP_SRL:  res_nxt = a >> shamt;
            default: res_nxt = '0;
        endcase
    end

    // zero is derived from the same next-state value so both outputs move
    // together on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= res_nxt;
            zero   <= (res_nxt == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (N = 64)
//
// Linear sequence of directed steps followed by a randomized stream with
// occasional reset pulses. Expected values come from a behavioural model
// written straight from the operation table.
// ---------------------------------------------------------------------------
module tb_alu;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ALUControl;
    logic [N-1:0] result;
    logic         zero;

    int total = 0;
    int bad   = 0;

    alu #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .result     (result),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] model(input logic [N-1:0] x,
                                           input logic [N-1:0] y,
                                           input logic [3:0]   op);
        logic [N-1:0] r;
        int unsigned  sh;
        sh = int'(y % N);
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = y;
            4'b1100: r = ~(x | y);
            4'b0011: r = x ^ y;
            4'b1000: r = x << sh;
            4'b1001: r = x >> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] er, input logic ez);
        total++;
        assert (result === er) else begin
            bad++;
            $error("FAIL %s result got=%h exp=%h", tag, result, er);
        end
        total++;
        assert (zero === ez) else begin
            bad++;
            $error("FAIL %s zero got=%b exp=%b", tag, zero, ez);
        end
    endtask

    // Apply one set of inputs, clock once, check one cycle later.
    task automatic step(input string tag, input logic r, input logic [N-1:0] x,
                        input logic [N-1:0] y, input logic [3:0] op);
        logic [N-1:0] er;
        reset      = r;
        a          = x;
        b          = y;
        ALUControl = op;
        er = r ? '0 : model(x, y, op);
        @(posedge clk);
        #1;
        chk(tag, er, (er == '0));
    endtask

    initial begin
        logic [N-1:0] x, y, hold_r;
        logic [3:0]   op;
        logic         rr;

        reset = 1'b1; a = '0; b = '0; ALUControl = '0;

        // Reset dominates arbitrary inputs.
        step("rst0", 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h5, 4'b0010);
        step("rst1", 1'b1, 64'h1234, 64'h1234, 4'b0110);

        step("add5_3",   1'b0, 64'd5, 64'd3, 4'b0010);
        step("sub7_7",   1'b0, 64'd7, 64'd7, 4'b0110);
        step("sub0_1",   1'b0, 64'd0, 64'd1, 4'b0110);
        step("addwrap",  1'b0, {N{1'b1}}, 64'd1, 4'b0010);
        step("and",      1'b0, 64'hF0, 64'h3C, 4'b0000);
        step("or",       1'b0, 64'hF0, 64'h3C, 4'b0001);
        step("nor",      1'b0, 64'hF0, 64'h3C, 4'b1100);
        step("xor",      1'b0, 64'hF0, 64'h3C, 4'b0011);
        step("pass",     1'b0, 64'hF0, 64'h3C, 4'b0111);
        step("sll63",    1'b0, 64'd1, 64'd63, 4'b1000);
        step("srl7",     1'b0, 64'h80, 64'd7, 4'b1001);
        step("sllhi",    1'b0, 64'h3, 64'h140, 4'b1000);  // amount uses low 6 bits
        step("srl0",     1'b0, 64'hA5, 64'h0, 4'b1001);
        step("inv1111",  1'b0, 64'hFF, 64'hFF, 4'b1111);
        step("inv0100",  1'b0, 64'hFF, 64'h1, 4'b0100);

        // Spot-check a few directed values against literal constants too.
        step("lit_nor", 1'b0, 64'hF0, 64'h3C, 4'b1100);
        total++;
        assert (result === 64'hFFFF_FFFF_FFFF_FF03) else begin
            bad++;
            $error("FAIL lit_nor got=%h exp=%h", result, 64'hFFFF_FFFF_FFFF_FF03);
        end
        step("lit_sll", 1'b0, 64'd1, 64'd63, 4'b1000);
        total++;
        assert (result === 64'h8000_0000_0000_0000) else begin
            bad++;
            $error("FAIL lit_sll got=%h exp=%h", result, 64'h8000_0000_0000_0000);
        end

        // Outputs must not follow input changes between edges.
        step("hold_pre", 1'b0, 64'h1111, 64'h2222, 4'b0001);
        hold_r = result;
        a = 64'hFFFF; b = 64'h0; ALUControl = 4'b0110;
        #3;
        total++;
        assert (result === hold_r) else begin
            bad++;
            $error("FAIL hold got=%h exp=%h", result, hold_r);
        end
        step("hold_post", 1'b0, 64'hFFFF, 64'h0, 4'b0110);

        // Back-to-back with a mid-stream reset pulse.
        step("b2b0", 1'b0, 64'd10, 64'd4, 4'b0010);
        step("b2b1", 1'b0, 64'd10, 64'd4, 4'b0110);
        step("b2brst", 1'b1, 64'd10, 64'd4, 4'b0001);
        step("b2b2", 1'b0, 64'd10, 64'd4, 4'b0011);
        step("b2b3", 1'b0, 64'd10, 64'd2, 4'b1000);

        // Randomized stream; operands biased toward small/edge values sometimes.
        for (int i = 0; i < 300; i++) begin
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) y = x;            // exercises zero flag
            if ($urandom_range(0, 5) == 0) y = 64'($urandom_range(0, 70));
            op = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 15) == 0);
            step("rand", rr, x, y, op);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
